// File: rtl/screen_plotter_if.sv
// Pixel-write / ROM-fetch bundle between game control, screen ROM mux,
// VGA adapter and the screen plotter.
interface screen_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W   = 15
);
  logic                start;
  logic [1:0]          screen_sel;
  logic [1:0]          rom_sel;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                plot_done;

  // Control / ROM / VGA side
  modport master (
    output start, screen_sel, rom_data,
    input  rom_sel, rom_addr, x, y, colour, plot, busy, plot_done
  );

  // Plotter side
  modport slave (
    input  start, screen_sel, rom_data,
    output rom_sel, rom_addr, x, y, colour, plot, busy, plot_done
  );
endinterface

// File: rtl/screen_plotter.sv
// Full-frame drawing engine: sweeps every pixel in raster order, fetches
// its colour from the selected screen ROM (1-cycle read latency) and
// drives the VGA pixel-write port, then pulses plot_done to control.
module screen_plotter #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W   = 15
) (
  input logic            clk,
  input logic            reset,   // asynchronous, active-low
  screen_plotter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  logic [1:0]          state_q, state_d;
  logic [X_W-1:0]      cx_q, cx_d;
  logic [Y_W-1:0]      cy_q, cy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // First pipeline stage: coordinates of the pixel whose ROM read is in flight
  logic [X_W-1:0]      px_q;
  logic [Y_W-1:0]      py_q;
  logic                pv_q;

  // Second stage: registered VGA outputs, aligned with the ROM data
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic                plot_q;
  logic [COLOUR_W-1:0] colour_q;

  // Next-state, sweep counter and screen-select latch logic
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the plot_done cycle is dropped.
        if (bus.start && !done_q) begin
          sel_d   = bus.screen_sel;
          cx_d    = '0;
          cy_d    = '0;
          addr_d  = '0;
          state_d = S_SWEEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        if (cx_q == X_LAST) begin
          if (cy_q == Y_LAST) begin
            // Hold on the last address so rom_addr never passes the frame end.
            state_d = S_FLUSH;
          end else begin
            cx_d   = '0;
            cy_d   = cy_q + Y_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          cx_d   = cx_q + X_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // plot_done trails S_DONE by one register so it follows the last plot.
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // Control state, counters and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      addr_q  <= '0;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Two-stage coordinate pipeline matching the ROM latency plus colour register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_q     <= '0;
      py_q     <= '0;
      pv_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      plot_q   <= 1'b0;
      colour_q <= '0;
    end else begin
      px_q     <= cx_q;
      py_q     <= cy_q;
      pv_q     <= (state_q == S_SWEEP);
      x_q      <= px_q;
      y_q      <= py_q;
      plot_q   <= pv_q;
      colour_q <= bus.rom_data;
    end
  end

  assign bus.rom_sel   = sel_q;
  assign bus.rom_addr  = addr_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.plot_done = done_q;

endmodule

// File: tb/tb_screen_plotter.sv
// Directed bench for screen_plotter: a 4x3 instance for detailed cycle
// checks and a default 160x120 instance for full-frame checks.
module tb_screen_plotter;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  screen_plotter_if if_s ();
  screen_plotter_if if_f ();

  screen_plotter #(.WIDTH(4), .HEIGHT(3)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s.slave)
  );

  screen_plotter dut_f (
    .clk   (clk),
    .reset (reset),
    .bus   (if_f.slave)
  );

  // Synchronous ROM models: colour = low 3 address bits, one cycle later
  always @(posedge clk) if_s.rom_data <= if_s.rom_addr[2:0];
  always @(posedge clk) if_f.rom_data <= if_f.rom_addr[2:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Small frame: start with sel at the current negedge, check k=0..14 after E0
  task automatic run_small(input logic [1:0] sel);
    int p;
    if_s.start = 1'b1;
    if_s.screen_sel = sel;
    @(posedge clk);
    @(negedge clk);
    if_s.start = 1'b0;
    if_s.screen_sel = ~sel;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      chk("s_plot", if_s.plot, (k >= 2 && k <= 13));
      chk("s_busy", if_s.busy, 1);
      chk("s_done", if_s.plot_done, (k == 14));
      chk("s_rom_sel", if_s.rom_sel, sel);
      if (k >= 2 && k <= 13) begin
        p = k - 2;
        chk("s_x", if_s.x, p % 4);
        chk("s_y", if_s.y, p / 4);
        chk("s_colour", if_s.colour, p & 7);
      end
    end
  endtask

  // Full frame on the default instance, optional mid-sweep start/sel poke
  task automatic run_full(input logic [1:0] sel, input bit inject);
    int plots, errs, sel_errs, dones, done_k, max_addr, last_x, last_y;
    plots = 0; errs = 0; sel_errs = 0; dones = 0; done_k = -1;
    max_addr = 0; last_x = -1; last_y = -1;
    if_f.start = 1'b1;
    if_f.screen_sel = sel;
    @(posedge clk);
    @(negedge clk);
    if_f.start = 1'b0;
    for (int k = 0; k <= 19206; k++) begin
      if (k > 0) @(negedge clk);
      if (inject && k == 5000) begin
        if_f.start = 1'b1;
        if_f.screen_sel = 2'd0;
      end
      if (inject && k == 5001) if_f.start = 1'b0;
      if (if_f.rom_addr > max_addr) max_addr = int'(if_f.rom_addr);
      if (if_f.rom_sel !== sel) sel_errs++;
      if (if_f.plot === 1'b1) begin
        if (k != plots + 2 || if_f.x !== 8'(plots % 160) ||
            if_f.y !== 7'(plots / 160) || if_f.colour !== 3'(plots & 7))
          errs++;
        last_x = int'(if_f.x);
        last_y = int'(if_f.y);
        plots++;
      end
      if (if_f.plot_done === 1'b1) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
    end
    chk("f_plot_count", plots, 19200);
    chk("f_raster_errs", errs, 0);
    chk("f_rom_sel_errs", sel_errs, 0);
    chk("f_last_x", last_x, 159);
    chk("f_last_y", last_y, 119);
    chk("f_max_addr", max_addr, 19199);
    chk("f_done_count", dones, 1);
    chk("f_done_cycle", done_k, 19202);
    chk("f_busy_end", if_f.busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    if_s.start = 1'b0; if_s.screen_sel = 2'd0;
    if_f.start = 1'b0; if_f.screen_sel = 2'd0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_plot", if_s.plot, 0);
    chk("rst_busy", if_s.busy, 0);
    chk("rst_done", if_s.plot_done, 0);
    chk("rst_x", if_s.x, 0);
    chk("rst_y", if_s.y, 0);
    chk("rst_colour", if_s.colour, 0);
    chk("rst_rom_sel", if_s.rom_sel, 0);
    chk("rst_rom_addr", if_s.rom_addr, 0);
    chk("rst_f_plot", if_f.plot, 0);
    chk("rst_f_rom_addr", if_f.rom_addr, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_plot", if_s.plot, 0);
      chk("idle_done", if_s.plot_done, 0);
      chk("idle_busy", if_s.busy, 0);
      chk("idle_f_plot", if_f.plot, 0);
    end

    // Small frame, sel=2
    run_small(2'd2);

    // Back-to-back: start in the plot_done cycle is ignored
    if_s.start = 1'b1;
    if_s.screen_sel = 2'd1;
    @(negedge clk);
    chk("b2b_ignored_busy", if_s.busy, 0);
    chk("b2b_ignored_done", if_s.plot_done, 0);
    chk("b2b_ignored_sel", if_s.rom_sel, 2);
    // start still high: accepted on the next edge, one clean frame
    run_small(2'd1);
    @(negedge clk);
    chk("b2b_idle_busy", if_s.busy, 0);
    chk("b2b_idle_done", if_s.plot_done, 0);
    chk("b2b_idle_plot", if_s.plot, 0);

    // Reset mid-operation at pixel 5
    if_s.start = 1'b1;
    if_s.screen_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    if_s.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_pix5_plot", if_s.plot, 1);
    chk("mid_pix5_x", if_s.x, 1);
    chk("mid_pix5_y", if_s.y, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_plot", if_s.plot, 0);
    chk("mid_rst_busy", if_s.busy, 0);
    chk("mid_rst_x", if_s.x, 0);
    chk("mid_rst_y", if_s.y, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_nodone", if_s.plot_done, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("post_rst_nodone", if_s.plot_done, 0);
      chk("post_rst_noplot", if_s.plot, 0);
    end
    run_small(2'd0);

    // Full default frame, sel=3
    @(negedge clk);
    run_full(2'd3, 1'b0);

    // Full frame with start and sel=0 poked mid-sweep, sel=1
    @(negedge clk);
    run_full(2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
